// File: rtl/key_arb_pkg.sv
// Shared definitions for the key arbiter.
// Holds the default PS/2 scan codes (bit 8 = E0 extended prefix) of the game
// keys and the state encoding of the auto-repeat timer.
package key_arb_pkg;

  localparam int KEY_W = 9;

  localparam logic [KEY_W-1:0] KEY_LEFT  = 9'h16B;
  localparam logic [KEY_W-1:0] KEY_RIGHT = 9'h174;
  localparam logic [KEY_W-1:0] KEY_UP    = 9'h175;
  localparam logic [KEY_W-1:0] KEY_DOWN  = 9'h172;
  localparam logic [KEY_W-1:0] KEY_SPACE = 9'h029;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT
  } repeat_state_t;

endpackage

// File: rtl/key_repeat_timer.sv
// Typematic pulse generator for the selected key.
// Ports:
//   clk, reset    clock, asynchronous active-high reset
//   active_valid  a key is currently selected
//   key_changed   the selected key index differs from last cycle's
//   enable        pulse generation allowed
//   action_pulse  registered one-cycle pulse: new selection or repeat tick
module key_repeat_timer
  import key_arb_pkg::*;
#(
  parameter int REPEAT_DELAY  = 25_000_000,
  parameter int REPEAT_PERIOD = 5_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic active_valid,
  input  logic key_changed,
  input  logic enable,
  output logic action_pulse
);

  localparam int MAX_CNT = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CW      = $clog2(MAX_CNT);

  repeat_state_t state;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      action_pulse <= 1'b0;
    end else if (!active_valid || !enable) begin
      state        <= IDLE;
      cnt          <= '0;
      action_pulse <= 1'b0;
    end else if (state == IDLE || key_changed) begin
      // A restart that lands on a repeat pulse is pushed back one cycle via
      // IDLE so two pulses never touch.
      if (action_pulse) begin
        state        <= IDLE;
        cnt          <= '0;
        action_pulse <= 1'b0;
      end else begin
        state        <= DELAY;
        cnt          <= CW'(REPEAT_DELAY - 1);
        action_pulse <= 1'b1;
      end
    end else if (cnt == '0) begin
      state        <= REPEAT;
      cnt          <= CW'(REPEAT_PERIOD - 1);
      action_pulse <= 1'b1;
    end else begin
      cnt          <= cnt - 1'b1;
      action_pulse <= 1'b0;
    end
  end

endmodule

// File: rtl/key_arbiter.sv
// Game-key arbiter fed by the PS/2 decoder strobes.
// Tracks held keys in a recency stack (top = most recently pressed) and
// selects the top entry; the repeat timer turns selections into action pulses.
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   keyCode      scan code, bit 8 = E0 prefix
//   make/brakee  one-cycle press / release strobes for keyCode
//   enable       gates pulse generation only
//   keyHeldVec   per-key held flags
//   activeKey    selected key index (0 when none)
//   activeValid  any arbitrated key held
//   actionPulse  one-cycle action pulse
module key_arbiter
  import key_arb_pkg::*;
#(
  parameter int                        NUM_KEYS      = 4,
  parameter logic [NUM_KEYS*KEY_W-1:0] KEY_CODES     = {KEY_DOWN, KEY_UP, KEY_RIGHT, KEY_LEFT},
  parameter int                        REPEAT_DELAY  = 25_000_000,
  parameter int                        REPEAT_PERIOD = 5_000_000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [KEY_W-1:0]            keyCode,
  input  logic                        make,
  input  logic                        brakee,
  input  logic                        enable,
  output logic [NUM_KEYS-1:0]         keyHeldVec,
  output logic [$clog2(NUM_KEYS)-1:0] activeKey,
  output logic                        activeValid,
  output logic                        actionPulse
);

  localparam int KW = $clog2(NUM_KEYS);

  logic [KW-1:0]       stk_key [NUM_KEYS];
  logic [NUM_KEYS-1:0] stk_vld;
  logic [KW-1:0]       nxt_key [NUM_KEYS];
  logic [NUM_KEYS-1:0] nxt_vld;
  logic [NUM_KEYS-1:0] nxt_held;
  logic [KW-1:0]       last_key;
  logic                hit;
  logic [KW-1:0]       hidx;
  logic                shift;
  logic                key_changed;

  // Descending scan so the lowest matching index is the one kept.
  always_comb begin
    hit  = 1'b0;
    hidx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (KEY_CODES[i*KEY_W +: KEY_W] == keyCode) begin
        hit  = 1'b1;
        hidx = KW'(i);
      end
    end
  end

  // Release is tested first so make+brakee on one key leaves it released.
  always_comb begin
    nxt_key  = stk_key;
    nxt_vld  = stk_vld;
    nxt_held = keyHeldVec;
    shift    = 1'b0;
    if (brakee && hit && keyHeldVec[hidx]) begin
      // Entries from the released key downward move up one place.
      for (int j = 0; j < NUM_KEYS - 1; j++) begin
        if (stk_vld[j] && stk_key[j] == hidx) shift = 1'b1;
        if (shift) begin
          nxt_key[j] = stk_key[j+1];
          nxt_vld[j] = stk_vld[j+1];
        end
      end
      nxt_key[NUM_KEYS-1] = '0;
      nxt_vld[NUM_KEYS-1] = 1'b0;
      nxt_held[hidx]      = 1'b0;
    end else if (make && !brakee && hit && !keyHeldVec[hidx]) begin
      nxt_key[0] = hidx;
      nxt_vld[0] = 1'b1;
      for (int j = 1; j < NUM_KEYS; j++) begin
        nxt_key[j] = stk_key[j-1];
        nxt_vld[j] = stk_vld[j-1];
      end
      nxt_held[hidx] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int j = 0; j < NUM_KEYS; j++) stk_key[j] <= '0;
      stk_vld     <= '0;
      keyHeldVec  <= '0;
      activeKey   <= '0;
      activeValid <= 1'b0;
      last_key    <= '0;
    end else begin
      stk_key     <= nxt_key;
      stk_vld     <= nxt_vld;
      keyHeldVec  <= nxt_held;
      activeKey   <= nxt_vld[0] ? nxt_key[0] : '0;
      activeValid <= nxt_vld[0];
      last_key    <= activeKey;
    end
  end

  assign key_changed = activeValid && (activeKey != last_key);

  key_repeat_timer #(
    .REPEAT_DELAY  (REPEAT_DELAY),
    .REPEAT_PERIOD (REPEAT_PERIOD)
  ) u_timer (
    .clk          (clk),
    .reset        (reset),
    .active_valid (activeValid),
    .key_changed  (key_changed),
    .enable       (enable),
    .action_pulse (actionPulse)
  );

endmodule

// File: tb/tb_key_arbiter.sv
// Directed bench for key_arbiter with REPEAT_DELAY=10, REPEAT_PERIOD=4.
// Cycle c is the interval after the c-th sampled edge of a test; actionPulse
// is recorded per cycle into a bit mask and compared with hand-derived masks.
module tb_key_arbiter;
  import key_arb_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [8:0] keyCode;
  logic       make;
  logic       brakee;
  logic       enable;
  logic [3:0] keyHeldVec;
  logic [1:0] activeKey;
  logic       activeValid;
  logic       actionPulse;

  int          checks = 0;
  int          errors = 0;
  int          cnum;
  logic [63:0] pmask;

  key_arbiter #(
    .NUM_KEYS      (4),
    .REPEAT_DELAY  (10),
    .REPEAT_PERIOD (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .keyCode     (keyCode),
    .make        (make),
    .brakee      (brakee),
    .enable      (enable),
    .keyHeldVec  (keyHeldVec),
    .activeKey   (activeKey),
    .activeValid (activeValid),
    .actionPulse (actionPulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] held, input logic [1:0] key,
                         input logic vld);
    chk({tag, ".held"}, 64'(keyHeldVec), 64'(held));
    chk({tag, ".key"}, 64'(activeKey), 64'(key));
    chk({tag, ".valid"}, 64'(activeValid), 64'(vld));
  endtask

  // Record this cycle's pulse, then advance to just after the next edge.
  task automatic cyc();
    if (cnum < 64) pmask[cnum] = actionPulse;
    @(posedge clk);
    #1;
    make   = 1'b0;
    brakee = 1'b0;
    cnum++;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  task automatic press(input logic [8:0] code);
    keyCode = code;
    make    = 1'b1;
    cyc();
  endtask

  task automatic release_key(input logic [8:0] code);
    keyCode = code;
    brakee  = 1'b1;
    cyc();
  endtask

  task automatic start_test();
    pmask = '0;
    cnum  = 0;
  endtask

  task automatic end_test(input string tag, input logic [63:0] exp_mask);
    chk({tag, ".pulses"}, pmask, exp_mask);
    chk({tag, ".noadj"}, pmask & (pmask >> 1), 64'h0);
  endtask

  initial begin
    reset   = 1'b1;
    keyCode = '0;
    make    = 1'b0;
    brakee  = 1'b0;
    enable  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_out("reset", 4'b0000, 2'd0, 1'b0);
    chk("reset.pulse", 64'(actionPulse), 64'h0);
    reset = 1'b0;
    idle(2);

    // Single press: pulses at 2,12,16,20,24,28; all clear at 31.
    start_test();
    press(KEY_LEFT);
    chk_out("single.c1", 4'b0001, 2'd0, 1'b1);
    idle(29);
    release_key(KEY_LEFT);
    chk_out("single.c31", 4'b0000, 2'd0, 1'b0);
    chk("single.c31.pulse", 64'(actionPulse), 64'h0);
    idle(4);
    end_test("single", 64'h1111_1004);

    // Priority: right taken at 5 (pulse 7, repeat 17), released at 18 so
    // left regains selection at 19 and restarts with a pulse at 20.
    start_test();
    press(KEY_LEFT);
    idle(4);
    chk_out("prio.c5", 4'b0001, 2'd0, 1'b1);
    press(KEY_RIGHT);
    chk_out("prio.c6", 4'b0011, 2'd1, 1'b1);
    idle(12);
    release_key(KEY_RIGHT);
    chk_out("prio.c19", 4'b0001, 2'd0, 1'b1);
    idle(5);
    release_key(KEY_LEFT);
    chk_out("prio.c25", 4'b0000, 2'd0, 1'b0);
    idle(5);
    end_test("prio", 64'h0012_0084);

    // Typematic re-press changes nothing: pulses 2,12,16 only.
    start_test();
    press(KEY_LEFT);
    idle(4);
    press(KEY_LEFT);
    idle(3);
    press(KEY_LEFT);
    chk_out("typem.c10", 4'b0001, 2'd0, 1'b1);
    idle(8);
    release_key(KEY_LEFT);
    idle(4);
    end_test("typem", 64'h0001_1004);

    // Stack ordering and middle removal.
    start_test();
    press(KEY_LEFT);
    press(KEY_RIGHT);
    press(KEY_LEFT);
    chk_out("stack.repress", 4'b0011, 2'd1, 1'b1);
    press(KEY_UP);
    chk_out("stack.up", 4'b0111, 2'd2, 1'b1);
    release_key(KEY_RIGHT);
    chk_out("stack.mid", 4'b0101, 2'd2, 1'b1);
    release_key(KEY_UP);
    chk_out("stack.top", 4'b0001, 2'd0, 1'b1);
    release_key(KEY_LEFT);
    release_key(KEY_LEFT);
    chk_out("stack.empty", 4'b0000, 2'd0, 1'b0);
    idle(3);
    chk("stack.noadj", pmask & (pmask >> 1), 64'h0);

    // Simultaneous make+brakee, then an unmatched code.
    start_test();
    keyCode = KEY_RIGHT;
    make    = 1'b1;
    brakee  = 1'b1;
    cyc();
    chk_out("simul", 4'b0000, 2'd0, 1'b0);
    press(9'h01C);
    chk_out("unmatched", 4'b0000, 2'd0, 1'b0);
    idle(4);
    end_test("simul", 64'h0);

    // Enable low over cycles 4..20: only pulses 2 and 22.
    start_test();
    press(KEY_LEFT);
    idle(3);
    enable = 1'b0;
    idle(17);
    chk_out("enable.low", 4'b0001, 2'd0, 1'b1);
    enable = 1'b1;
    idle(3);
    release_key(KEY_LEFT);
    idle(3);
    end_test("enable", 64'h0040_0004);

    // Reset at cycle 14 mid-repeat; next pulse only two cycles after make at 24.
    start_test();
    press(KEY_LEFT);
    idle(13);
    reset = 1'b1;
    #2;
    chk_out("rst.async", 4'b0000, 2'd0, 1'b0);
    chk("rst.async.pulse", 64'(actionPulse), 64'h0);
    reset = 1'b0;
    idle(6);
    release_key(KEY_LEFT);
    idle(3);
    press(KEY_LEFT);
    chk_out("rst.repress", 4'b0001, 2'd0, 1'b1);
    idle(3);
    release_key(KEY_LEFT);
    idle(3);
    end_test("rst", 64'h0400_1004);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
